// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared FSM state, bus cycle types and IO constants for the Z80 bus responder.
package z80_bus_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_e;
    typedef enum logic [2:0] {MEM_RD, MEM_WR, IO_RD, IO_WR, INTACK} cyc_e;
    localparam int         IO_PORTS    = 16;
    localparam logic [7:0] IO_OPEN_BUS = 8'hFF;
endpackage

// File: rtl/z80_resp_ram.sv
// z80_resp_ram: single-port byte RAM with synchronous read and write, 2**MEM_AW deep.
module z80_resp_ram #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [MEM_AW-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o
);
    logic [7:0] mem_q [2**MEM_AW];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/z80_bus_responder.sv
// z80_bus_responder: Z80 memory/IO bus slave with wait-state insertion and a RAM preload port.
// Define Z80_RESP_INTACK_EN to answer interrupt-acknowledge cycles with int_vec.
module z80_bus_responder
    import z80_bus_pkg::*;
#(
    parameter int MEM_AW      = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        rfsh_n,
    input  logic [15:0] A,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_di,
    output logic        wait_n,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data
`ifdef Z80_RESP_INTACK_EN
    ,
    input  logic [7:0]  int_vec
`endif
);
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    state_e      state_q;
    cyc_e        cyc_q;
    cyc_e        cyc_d;
    logic [3:0]  cnt_q;
    logic [7:0]  cpu_di_q;
    logic [7:0]  io_q [IO_PORTS];
    logic        mem_c, io_c, ack, req, io_hit, done_exit, ram_we;
    logic [7:0]  ram_rdata;
    logic        unused_addr_bits;
    assign mem_c = !mreq_n && rfsh_n;
    assign io_c  = !iorq_n && m1_n;
`ifdef Z80_RESP_INTACK_EN
    assign ack       = !m1_n && !iorq_n;
    assign done_exit = (cyc_q == INTACK) ? iorq_n : (rd_n && wr_n);
`else
    assign ack       = 1'b0;
    assign done_exit = rd_n && wr_n;
`endif
    assign req    = ((mem_c || io_c) && (!rd_n || !wr_n)) || ack;
    assign cyc_d  = ack ? INTACK : mem_c ? (!rd_n ? MEM_RD : MEM_WR) : (!rd_n ? IO_RD : IO_WR);
    assign io_hit = A[7:0] < 8'(IO_PORTS);
    assign ld_ready = !reset && state_q == IDLE && !req;
    // The request cycle in IDLE is the first wait cycle, so the final WAIT cycle releases wait_n.
    assign wait_n = reset || !((state_q == IDLE && req && WAIT_STATES > 0) ||
                               (state_q == WAIT && cnt_q != 4'd0));
    assign ram_we = (ld_valid && ld_ready) || (state_q == ACCESS && cyc_q == MEM_WR && !reset);
    assign cpu_di = cpu_di_q;
    assign unused_addr_bits = ^{A, ld_addr};
    z80_resp_ram #(.MEM_AW(MEM_AW)) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .addr_i (ld_ready ? ld_addr[MEM_AW-1:0] : A[MEM_AW-1:0]),
        .wdata_i(ld_ready ? ld_data : cpu_dout),
        .rdata_o(ram_rdata)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cyc_q    <= MEM_RD;
            cnt_q    <= 4'd0;
            cpu_di_q <= IO_OPEN_BUS;
            for (int i = 0; i < IO_PORTS; i++) io_q[i] <= 8'h00;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    cyc_q   <= cyc_d;
                    cnt_q   <= WS_LOAD;
                    state_q <= (WAIT_STATES > 0) ? WAIT : ACCESS;
                end
                WAIT: begin
                    if (cnt_q == 4'd0) state_q <= ACCESS;
                    else cnt_q <= cnt_q - 4'd1;
                end
                ACCESS: begin
                    state_q <= DONE;
                    case (cyc_q)
                        MEM_RD: cpu_di_q <= ram_rdata;
                        IO_RD:  cpu_di_q <= io_hit ? io_q[A[3:0]] : IO_OPEN_BUS;
                        IO_WR:  if (io_hit) io_q[A[3:0]] <= cpu_dout;
`ifdef Z80_RESP_INTACK_EN
                        INTACK: cpu_di_q <= int_vec;
`endif
                        default: ;
                    endcase
                end
                DONE: if (done_exit) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_z80_bus_responder.sv
// tb_z80_bus_responder: directed scoreboard bench driving a zero-wait and a two-wait responder on one bus.
module tb_z80_bus_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1, rfsh_n = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_addr = 16'h0000;
    logic [7:0]  ld_data = 8'h00;
    logic [7:0]  di0, di2;
    logic        wn0, wn2, rdy0, rdy2;
`ifdef Z80_RESP_INTACK_EN
    logic [7:0]  int_vec = 8'hFF;
`endif
    typedef struct {
        string      name;
        logic [7:0] exp;
    } exp_t;
    exp_t sb[$];
    int   vecs = 0;
    int   errs = 0;
    logic rd_prev = 1'b1;

    always #5 clk = ~clk;

    z80_bus_responder #(.MEM_AW(12), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .m1_n(m1_n), .rfsh_n(rfsh_n), .A(A), .cpu_dout(cpu_dout), .cpu_di(di0), .wait_n(wn0),
        .ld_valid(ld_valid), .ld_ready(rdy0), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef Z80_RESP_INTACK_EN
        , .int_vec(int_vec)
`endif
    );
    z80_bus_responder #(.MEM_AW(12), .WAIT_STATES(2)) u2 (
        .clk(clk), .reset(reset), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .m1_n(m1_n), .rfsh_n(rfsh_n), .A(A), .cpu_dout(cpu_dout), .cpu_di(di2), .wait_n(wn2),
        .ld_valid(ld_valid), .ld_ready(rdy2), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef Z80_RESP_INTACK_EN
        , .int_vec(int_vec)
`endif
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %02h, want %02h", name, act, exp);
        end
    endtask

    // Monitor: the CPU latches read data when it releases rd_n, so compare both DUTs there.
    initial forever begin
        @(negedge clk);
        #2;
        if (rd_prev === 1'b0 && rd_n === 1'b1 && !reset) begin
            if (sb.size() == 0) chk("unexpected_read", 8'h01, 8'h00);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "/ws0"}, di0, e.exp);
                chk({e.name, "/ws2"}, di2, e.exp);
            end
        end
        rd_prev = rd_n;
    end

    task automatic push_exp(input string name, input logic [7:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic bus(input bit io, input bit wr, input logic [15:0] addr, input logic [7:0] d,
                       input logic [7:0] exp, input string name);
        int l0 = 0;
        int l2 = 0;
        @(negedge clk);
        A = addr;
        cpu_dout = d;
        if (io) iorq_n = 1'b0; else mreq_n = 1'b0;
        if (wr) wr_n = 1'b0; else rd_n = 1'b0;
        if (!wr) push_exp(name, exp);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (!wn0) l0++;
            if (!wn2) l2++;
            if (!wr && i == 2) chk({name, "@2cyc"}, di0, exp);
            if (wr && i == 5) cpu_dout = ~d;
        end
        chk({name, " wait_lo_ws0"}, 8'(l0), 8'd0);
        chk({name, " wait_lo_ws2"}, 8'(l2), 8'd2);
        @(negedge clk);
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        #1;
        chk("preload ld_ready0", 8'(rdy0), 8'd1);
        chk("preload ld_ready2", 8'(rdy2), 8'd1);
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst cpu_di0", di0, 8'hFF);
        chk("rst cpu_di2", di2, 8'hFF);
        chk("rst wait_n0", 8'(wn0), 8'd1);
        chk("rst wait_n2", 8'(wn2), 8'd1);
        chk("rst ld_ready0", 8'(rdy0), 8'd0);
        chk("rst ld_ready2", 8'(rdy2), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        preload(16'h038F, 8'hBA);
        preload(16'h0100, 8'h11);
        bus(0, 0, 16'h038F, 8'h00, 8'hBA, "mem_rd_038f");
        bus(0, 1, 16'h1234, 8'h5A, 8'h00, "mem_wr_1234");
        bus(0, 0, 16'h0234, 8'h00, 8'h5A, "wrap_rd_0234");
        bus(1, 0, 16'h0000, 8'h00, 8'h00, "io_rd_00_reset");
        bus(1, 1, 16'h0005, 8'h3C, 8'h00, "io_wr_05");
        bus(1, 0, 16'hAB05, 8'h00, 8'h3C, "io_rd_05");
        bus(1, 0, 16'h0020, 8'h00, 8'hFF, "io_rd_20_open");
        bus(1, 1, 16'h0020, 8'h99, 8'h00, "io_wr_20_ign");
        bus(1, 0, 16'h0000, 8'h00, 8'h00, "io_rd_00_after");
        bus(1, 0, 16'h0005, 8'h00, 8'h3C, "io_rd_05_after");
        bus(1, 0, 16'h000F, 8'h00, 8'h00, "io_rd_0f");
        bus(0, 1, 16'h0200, 8'h42, 8'h00, "mem_wr_0200_hold");
        bus(0, 0, 16'h0200, 8'h00, 8'h42, "mem_rd_0200_once");
        // reset during WAIT (ws2) / ACCESS (ws0) of a write to 0x0100
        @(negedge clk);
        A = 16'h0100; cpu_dout = 8'h77; mreq_n = 1'b0; wr_n = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("abort wait_n0", 8'(wn0), 8'd1);
        chk("abort wait_n2", 8'(wn2), 8'd1);
        chk("abort cpu_di0", di0, 8'hFF);
        chk("abort cpu_di2", di2, 8'hFF);
        mreq_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus(0, 0, 16'h0100, 8'h00, 8'h11, "abort_rd_0100");
        bus(1, 0, 16'h0005, 8'h00, 8'h00, "io_rd_05_cleared");
        // load stalled behind a CPU read, accepted in the first free IDLE cycle
        @(negedge clk);
        A = 16'h038F; mreq_n = 1'b0; rd_n = 1'b0;
        ld_valid = 1'b1; ld_addr = 16'h0400; ld_data = 8'hC7;
        push_exp("stall_rd_038f", 8'hBA);
        #1;
        chk("stall ld_ready0", 8'(rdy0), 8'd0);
        chk("stall ld_ready2", 8'(rdy2), 8'd0);
        repeat (6) @(negedge clk);
        mreq_n = 1'b1; rd_n = 1'b1;
        #1;
        chk("done ld_ready2", 8'(rdy2), 8'd0);
        @(negedge clk);
        #1;
        chk("free ld_ready0", 8'(rdy0), 8'd1);
        chk("free ld_ready2", 8'(rdy2), 8'd1);
        @(negedge clk);
        ld_valid = 1'b0;
        bus(0, 0, 16'h0400, 8'h00, 8'hC7, "stalled_load_rd");
        // interrupt acknowledge
        bus(0, 0, 16'h1234, 8'h00, 8'h5A, "pre_intack_rd");
        @(negedge clk);
        m1_n = 1'b0; iorq_n = 1'b0;
        #1;
`ifdef Z80_RESP_INTACK_EN
        chk("intack ld_ready0", 8'(rdy0), 8'd0);
`else
        chk("intack ld_ready0", 8'(rdy0), 8'd1);
`endif
        repeat (6) @(negedge clk);
        #1;
`ifndef Z80_RESP_INTACK_EN
        chk("intack idle ld_ready2", 8'(rdy2), 8'd1);
`endif
        m1_n = 1'b1; iorq_n = 1'b1;
        @(negedge clk);
        #1;
`ifdef Z80_RESP_INTACK_EN
        chk("intack cpu_di0", di0, 8'hFF);
        chk("intack cpu_di2", di2, 8'hFF);
`else
        chk("intack cpu_di0", di0, 8'h5A);
        chk("intack cpu_di2", di2, 8'h5A);
`endif
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 8'(sb.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/z80_bus_responder.md
Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

Interface
REQ-001 The block SHALL have parameter MEM_AW, default 12, meaning memory address width (RAM depth = 2**MEM_AW bytes, range 8..16).
REQ-002 The block SHALL have parameter WAIT_STATES, default 0, meaning the number of wait cycles inserted per bus access (range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n, each input, 1 bit: CPU bus strobes, active-low.
REQ-006 The block SHALL have port A, input, 16 bits: CPU address.
REQ-007 The block SHALL have port cpu_dout, input, 8 bits: CPU write data.
REQ-008 The block SHALL have port cpu_di, output, 8 bits: registered read data to the CPU.
REQ-009 The block SHALL have port wait_n, output, 1 bit: wait request, active-low.
REQ-010 The block SHALL have load ports ld_valid (input, 1), ld_ready (output, 1), ld_addr (input, 16) and ld_data (input, 8), forming a preload handshake.
REQ-011 The block SHALL have port int_vec, input, 8 bits: interrupt-acknowledge vector (present only with Z80_RESP_INTACK_EN).

Function
REQ-012 A request SHALL be detected when (mreq_n=0 and rfsh_n=1) or (iorq_n=0 and m1_n=1), together with rd_n=0 or wr_n=0; refresh cycles SHALL be ignored.
REQ-013 The FSM states SHALL be IDLE, WAIT, ACCESS and DONE.
REQ-014 Transitions:
- IDLE->WAIT on request when WAIT_STATES>0, loading the counter with WAIT_STATES-1.
- IDLE->ACCESS on request when WAIT_STATES=0.
- WAIT->ACCESS when the counter reaches 0; otherwise the counter decrements.
- ACCESS->DONE unconditionally.
- DONE->IDLE when rd_n=1 and wr_n=1.
REQ-015 wait_n SHALL be 0 combinationally in IDLE while a request is present and WAIT_STATES>0, and throughout WAIT; it SHALL be 1 otherwise, giving exactly WAIT_STATES low cycles per access.
REQ-016 In ACCESS, the block SHALL perform exactly one operation:
- memory write: RAM[A[MEM_AW-1:0]] <= cpu_dout;
- memory read: cpu_di <= RAM data;
- IO write / IO read: IO register file.
The address SHALL wrap modulo 2**MEM_AW.
REQ-017 Read data SHALL be valid on cpu_di from the clock edge leaving ACCESS and SHALL be held through DONE and IDLE until the next read.
REQ-018 IO space SHALL hold 16 eight-bit port registers addressed by A[7:0] in the range 0x00..0x0F.
- Reads of A[7:0] >= 0x10 SHALL return 8'hFF.
- Writes to A[7:0] >= 0x10 SHALL be ignored.
REQ-019 A strobe still low in DONE SHALL NOT cause a second access; a new access SHALL require a return to IDLE.
REQ-020 ld_ready SHALL be 1 only in IDLE with no request detected; when ld_valid and ld_ready are both 1, RAM[ld_addr[MEM_AW-1:0]] <= ld_data.
REQ-021 When a CPU request and ld_valid coincide, the CPU request SHALL win and the load SHALL stall.

Reset
REQ-022 While reset=1, the block SHALL hold state=IDLE, counter=0, cpu_di=8'hFF, wait_n=1, ld_ready=0, and all IO registers at 8'h00.
REQ-023 RAM contents SHALL NOT be cleared by reset.
REQ-024 A reset during WAIT or ACCESS SHALL abort the access with no RAM or IO write.

Configuration
REQ-025 With Z80_RESP_INTACK_EN defined, the block SHALL treat m1_n=0 with iorq_n=0 as interrupt acknowledge.
- The access SHALL run through the same FSM, including wait states.
- In ACCESS, cpu_di <= int_vec.
- DONE SHALL exit when iorq_n=1.
REQ-026 Without Z80_RESP_INTACK_EN, the int_vec port SHALL be absent and interrupt-acknowledge cycles SHALL be ignored (no state change, cpu_di unchanged).

Structure
REQ-027 Shared package z80_bus_pkg SHALL hold the FSM state enum, the cycle-type enum (MEM_RD, MEM_WR, IO_RD, IO_WR, INTACK) and the constants IO_PORTS=16 and IO_OPEN_BUS=8'hFF.
REQ-028 The RAM SHALL be a sub-module z80_resp_ram: single-port, synchronous read and write, parameterised by MEM_AW.

Verification
REQ-029 Preload 0x038F=0xBA via the ld handshake; CPU memory read of 0x038F -> cpu_di=0xBA two cycles after request detection; wait_n stays 1.
REQ-030 MEM_AW=12: write 0x1234=0x5A, then read 0x0234 -> 0x5A (wrap).
REQ-031 IO write port 0x05=0x3C, then IO read 0x05 -> 0x3C; IO read 0x20 -> 0xFF; IO write 0x20 leaves all ports unchanged.
REQ-032 WAIT_STATES=2: memory read -> wait_n low for exactly 2 cycles; the strobe held low through DONE causes no second write.
REQ-033 Reset asserted in WAIT during a write of 0x77 to 0x0100 -> RAM[0x0100] unchanged, wait_n=1, cpu_di=0xFF; ld_valid stalled by a concurrent request is accepted in the first free IDLE cycle.
REQ-034 With Z80_RESP_INTACK_EN, int_vec=0xFF and an m1_n/iorq_n acknowledge -> cpu_di=0xFF; without the macro, the same cycle leaves state IDLE.
